// File: rtl/hdmi_mm_pkg.sv
// Shared types and constants for the HDMI Avalon-MM fill/readback master.
// Consumed by hdmi_mm_fill_master and hdmi_mm_pattern_gen.
package hdmi_mm_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned MAX_WORDS  = 1024;

  typedef enum logic {
    PAT_CONST = 1'b0,
    PAT_INCR  = 1'b1
  } pattern_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/hdmi_mm_pattern_gen.sv
// Combinational test-pattern generator: seed (constant mode) or seed+index (incrementing mode).
module hdmi_mm_pattern_gen
  import hdmi_mm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IDX_W  = ADDR_W_DEF + 1
) (
  input  logic [IDX_W-1:0]  index_i,
  input  logic [DATA_W-1:0] seed_i,
  input  pattern_mode_e     mode_i,
  output logic [DATA_W-1:0] pattern_o
);

  always_comb begin
    pattern_o = seed_i;
    if (mode_i == PAT_INCR) pattern_o = seed_i + DATA_W'(index_i);
  end

endmodule

// File: rtl/hdmi_mm_fill_master.sv
// Avalon-MM master that fills a word range with a generated pattern.
// Define HDMI_MM_READBACK_EN to add pipelined readback and mismatch counting.
module hdmi_mm_fill_master
  import hdmi_mm_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_cnt,
  input  logic                  pattern_mode,
  input  logic [DATA_W-1:0]     pattern_seed,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       err_cnt,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  master_write,
  output logic                  master_read,
  output logic [ADDR_W-1:0]     master_address,
  output logic [DATA_W-1:0]     master_writedata,
  output logic                  master_burstcount,
  output logic [DATA_W/8-1:0]   master_byteenable,
  input  logic                  master_waitrequest,
  input  logic                  master_readdatavalid,
  input  logic [DATA_W-1:0]     master_readdata
);

  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
  pattern_mode_e     mode_q, mode_d;
  logic [DATA_W-1:0] seed_q, seed_d;

  logic [CNT_W-1:0]  cnt_clamped;
  logic              wr_acc;
  logic              wr_last;
  logic              clear_results;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_off;

  assign cnt_clamped = (word_cnt > CNT_MAX) ? CNT_MAX : word_cnt;
  assign wr_acc      = master_write && !master_waitrequest;
  assign wr_last     = (wr_idx_q + CNT_ONE) == cnt_q;

  hdmi_mm_pattern_gen #(
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_wr_pattern (
    .index_i   (wr_idx_q),
    .seed_i    (seed_q),
    .mode_i    (mode_q),
    .pattern_o (wr_data)
  );

`ifdef HDMI_MM_READBACK_EN
  localparam int unsigned      PEND_W   = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              err_seen_q, err_seen_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              rd_acc;
  logic              rsp_acc;
  logic [DATA_W-1:0] cmp_exp;

  // The outstanding limit throttles issue; j < cnt holds throughout READ.
  assign master_read = (state_q == ST_READ) && (pend_q < PEND_W'(MAX_PEND));
  assign rd_acc      = master_read && !master_waitrequest;
  assign rsp_acc     = master_readdatavalid && (pend_q != '0) &&
                       ((state_q == ST_READ) || (state_q == ST_DRAIN));
  assign rd_off      = rd_idx_q[ADDR_W-1:0];

  hdmi_mm_pattern_gen #(
    .DATA_W (DATA_W),
    .IDX_W  (CNT_W)
  ) u_cmp_pattern (
    .index_i   (cmp_idx_q),
    .seed_i    (seed_q),
    .mode_i    (mode_q),
    .pattern_o (cmp_exp)
  );

  always_comb begin
    rd_idx_d    = rd_idx_q;
    cmp_idx_d   = cmp_idx_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_seen_d  = err_seen_q;
    pend_d      = pend_q;
    if (clear_results) begin
      rd_idx_d    = '0;
      cmp_idx_d   = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
      err_seen_d  = 1'b0;
      pend_d      = '0;
    end else begin
      if (rd_acc) rd_idx_d = rd_idx_q + CNT_ONE;
      if (rsp_acc) begin
        cmp_idx_d = cmp_idx_q + CNT_ONE;
        if (master_readdata != cmp_exp) begin
          if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_ONE;
          if (!err_seen_q) begin
            err_seen_d  = 1'b1;
            first_err_d = base_q + cmp_idx_q[ADDR_W-1:0];
          end
        end
      end
      case ({rd_acc, rsp_acc})
        2'b10:   pend_d = pend_q + PEND_ONE;
        2'b01:   pend_d = pend_q - PEND_ONE;
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_idx_q    <= '0;
      cmp_idx_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      rd_idx_q    <= rd_idx_d;
      cmp_idx_q   <= cmp_idx_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      err_seen_q  <= err_seen_d;
      pend_q      <= pend_d;
    end
  end

  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
`else
  logic unused_rb;

  assign master_read    = 1'b0;
  assign rd_off         = '0;
  assign err_cnt        = '0;
  assign first_err_addr = '0;
  assign unused_rb      = ^{master_readdatavalid, master_readdata, 32'(MAX_PEND)};
`endif

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    wr_idx_d      = wr_idx_q;
    mode_d        = mode_q;
    seed_d        = seed_q;
    clear_results = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_cnt == '0) begin
            state_d = ST_FINISH;
          end else begin
            base_d        = base_addr;
            cnt_d         = cnt_clamped;
            mode_d        = pattern_mode_e'(pattern_mode);
            seed_d        = pattern_seed;
            wr_idx_d      = '0;
            clear_results = 1'b1;
            state_d       = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (wr_acc) begin
          wr_idx_d = wr_idx_q + CNT_ONE;
`ifdef HDMI_MM_READBACK_EN
          if (wr_last) state_d = ST_READ;
`else
          if (wr_last) state_d = ST_FINISH;
`endif
        end
      end
`ifdef HDMI_MM_READBACK_EN
      ST_READ: begin
        if (rd_acc && ((rd_idx_q + CNT_ONE) == cnt_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pend_q == '0) state_d = ST_FINISH;
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      wr_idx_q <= '0;
      mode_q   <= PAT_CONST;
      seed_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      wr_idx_q <= wr_idx_d;
      mode_q   <= mode_d;
      seed_q   <= seed_d;
    end
  end

  // Request, address and data derive only from registers, so they hold under waitrequest.
  assign master_write      = (state_q == ST_WRITE);
  assign master_burstcount = 1'b1;
  assign master_byteenable = '1;
  assign busy              = state_q inside {ST_WRITE, ST_READ, ST_DRAIN};
  assign done              = (state_q == ST_FINISH);

  always_comb begin
    master_address   = '0;
    master_writedata = '0;
    if (master_write) begin
      master_address   = base_q + wr_idx_q[ADDR_W-1:0];
      master_writedata = wr_data;
    end else if (master_read) begin
      master_address = base_q + rd_off;
    end
  end

endmodule

// File: tb/tb_hdmi_mm_fill_master.sv
// Directed bench for hdmi_mm_fill_master with a memory slave model, stall injection and optional readback.
module tb_hdmi_mm_fill_master;

`ifdef HDMI_MM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int RD_LAT     = 5;
  localparam int DONE_LIMIT = 20000;

  logic        clk_clk;
  logic        reset_reset_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_cnt;
  logic        pattern_mode;
  logic [31:0] pattern_seed;
  logic        busy;
  logic        done;
  logic [10:0] err_cnt;
  logic [9:0]  first_err_addr;
  logic        master_write;
  logic        master_read;
  logic [9:0]  master_address;
  logic [31:0] master_writedata;
  logic        master_burstcount;
  logic [3:0]  master_byteenable;
  logic        master_waitrequest;
  logic        master_readdatavalid;
  logic [31:0] master_readdata;

  hdmi_mm_fill_master dut (
    .clk_clk              (clk_clk),
    .reset_reset_n        (reset_reset_n),
    .start                (start),
    .base_addr            (base_addr),
    .word_cnt             (word_cnt),
    .pattern_mode         (pattern_mode),
    .pattern_seed         (pattern_seed),
    .busy                 (busy),
    .done                 (done),
    .err_cnt              (err_cnt),
    .first_err_addr       (first_err_addr),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_burstcount    (master_burstcount),
    .master_byteenable    (master_byteenable),
    .master_waitrequest   (master_waitrequest),
    .master_readdatavalid (master_readdatavalid),
    .master_readdata      (master_readdata)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // Slave model state and traffic bookkeeping
  logic [31:0] mem [1024];
  int          hits [1024];
  int          log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc [$];
  logic [31:0] rsp_data [$];
  int          rsp_due [$];
  int          cyc = 0;
  int unsigned stall_max = 0;
  int unsigned stall_left = 0;
  bit          in_stall = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  int          wr_accepts = 0;
  int          rd_accepts = 0;
  int          rd_returned = 0;
  int          max_out = 0;
  int          done_pulses = 0;
  int          both_cnt = 0;
  int          corrupt_addr = -1;

  always @(negedge clk_clk) begin
    cyc++;
    if (!reset_reset_n) begin
      master_waitrequest   = 1'b0;
      master_readdatavalid = 1'b0;
      master_readdata      = '0;
      in_stall             = 1'b0;
      stall_left           = 0;
      prev_stall           = 1'b0;
      rsp_data.delete();
      rsp_due.delete();
    end else begin
      if (prev_stall) begin
        check("stall_hold_req", 32'(master_write), 32'd1);
        check("stall_hold_addr", 32'(master_address), prev_addr);
        check("stall_hold_data", master_writedata, prev_data);
      end
      if (master_write || master_read) begin
        if (!in_stall) stall_left = $urandom_range(stall_max);
        if (stall_left != 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
          in_stall = 1'b1;
        end else begin
          master_waitrequest = 1'b0;
          in_stall = 1'b0;
        end
      end else begin
        master_waitrequest = 1'b0;
        in_stall = 1'b0;
      end
      if (master_write && master_read) both_cnt++;
      prev_stall = master_write && master_waitrequest;
      prev_addr  = 32'(master_address);
      prev_data  = master_writedata;
      if (master_write && !master_waitrequest) begin
        mem[master_address] = master_writedata;
        hits[master_address]++;
        wr_accepts++;
        log_addr.push_back(int'(master_address));
        log_data.push_back(master_writedata);
        log_cyc.push_back(cyc);
      end
      if (master_read && !master_waitrequest) begin
        rsp_data.push_back(mem[master_address] ^
                           ((int'(master_address) == corrupt_addr) ? 32'h1 : 32'h0));
        rsp_due.push_back(cyc + RD_LAT);
        rd_accepts++;
      end
      if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata      = rsp_data.pop_front();
        void'(rsp_due.pop_front());
        rd_returned++;
      end else begin
        master_readdatavalid = 1'b0;
      end
      if (rd_accepts - rd_returned > max_out) max_out = rd_accepts - rd_returned;
      if (done) done_pulses++;
    end
  end

  task automatic clear_track();
    for (int i = 0; i < 1024; i++) hits[i] = 0;
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    wr_accepts  = 0;
    rd_accepts  = 0;
    rd_returned = 0;
    max_out     = 0;
    done_pulses = 0;
    both_cnt    = 0;
  endtask

  task automatic start_op(input int b, input int c, input bit m, input logic [31:0] s);
    @(negedge clk_clk);
    base_addr    = 10'(b);
    word_cnt     = 11'(c);
    pattern_mode = m;
    pattern_seed = s;
    start        = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
  endtask

  task automatic begin_op(input string tag, input int b, input int c, input bit m,
                          input logic [31:0] s, input int unsigned stall);
    clear_track();
    stall_max = stall;
    start_op(b, c, m, s);
    check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_op(input string tag, input int b, input int c, input bit m,
                           input logic [31:0] s, input int exp_err, input int exp_first);
    int cycles;
    int n;
    int bad;
    int addr;
    int total;
    int ret_at_done;
    logic [31:0] exp;
    cycles = 0;
    while (done !== 1'b1 && cycles < DONE_LIMIT) begin
      @(negedge clk_clk);
      cycles++;
    end
    ret_at_done = rd_returned;
    check({tag, ":done_seen"}, 32'(cycles < DONE_LIMIT), 32'd1);
    @(negedge clk_clk);
    check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    check({tag, ":busy_after_done"}, 32'(busy), 32'd0);
    n = (c > 1024) ? 1024 : c;
    check({tag, ":wr_count"}, 32'(wr_accepts), 32'(n));
    bad = 0;
    for (int i = 0; i < n; i++) begin
      addr = (b + i) % 1024;
      exp  = m ? s + 32'(i) : s;
      if (mem[addr] !== exp || hits[addr] != 1) bad++;
    end
    total = 0;
    for (int i = 0; i < 1024; i++) total += hits[i];
    check({tag, ":words_bad"}, 32'(bad), 32'd0);
    check({tag, ":hit_total"}, 32'(total), 32'(n));
    check({tag, ":done_pulses"}, 32'(done_pulses), 32'd1);
    check({tag, ":rw_overlap"}, 32'(both_cnt), 32'd0);
    check({tag, ":rd_count"}, 32'(rd_accepts), RB ? 32'(n) : 32'd0);
    check({tag, ":drain_wait"}, 32'(ret_at_done), RB ? 32'(n) : 32'd0);
    check({tag, ":max_pend_ok"}, 32'(max_out <= 4), 32'd1);
    check({tag, ":err_cnt"}, 32'(err_cnt), RB ? 32'(exp_err) : 32'd0);
    check({tag, ":first_err_addr"}, 32'(first_err_addr), RB ? 32'(exp_first) : 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ":write"}, 32'(master_write), 32'd0);
    check({tag, ":read"}, 32'(master_read), 32'd0);
    check({tag, ":address"}, 32'(master_address), 32'd0);
    check({tag, ":writedata"}, master_writedata, 32'd0);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":burstcount"}, 32'(master_burstcount), 32'd1);
    check({tag, ":byteenable"}, 32'(master_byteenable), 32'h0000000F);
  endtask

  initial begin
    reset_reset_n        = 1'b0;
    start                = 1'b0;
    base_addr            = '0;
    word_cnt             = '0;
    pattern_mode         = 1'b0;
    pattern_seed         = '0;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hCAFE0000 + 32'(i);

    repeat (2) @(negedge clk_clk);
    check_idle_outputs("reset");
    check("reset:err_cnt", 32'(err_cnt), 32'd0);
    check("reset:first_err_addr", 32'(first_err_addr), 32'd0);
    reset_reset_n = 1'b1;

    // Basic fill: 4 consecutive writes of 0x100..0x103 at 0x010..0x013
    begin_op("basic", 'h010, 4, 1'b1, 32'h100, 0);
    finish_op("basic", 'h010, 4, 1'b1, 32'h100, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic:addr%0d", i), 32'(log_addr[i]), 32'h10 + 32'(i));
      check($sformatf("basic:data%0d", i), log_data[i], 32'h100 + 32'(i));
    end
    check("basic:back_to_back", 32'(log_cyc[3] - log_cyc[0]), 32'd3);

    // Constant pattern with short stalls
    begin_op("const", 'h200, 5, 1'b0, 32'hDEADBEEF, 1);
    finish_op("const", 'h200, 5, 1'b0, 32'hDEADBEEF, 0, 0);

    // Wrap across the top of the address space
    begin_op("wrap", 'h3FE, 4, 1'b1, 32'hA0, 0);
    finish_op("wrap", 'h3FE, 4, 1'b1, 32'hA0, 0, 0);
    check("wrap:addr0", 32'(log_addr[0]), 32'h3FE);
    check("wrap:addr1", 32'(log_addr[1]), 32'h3FF);
    check("wrap:addr2", 32'(log_addr[2]), 32'h000);
    check("wrap:addr3", 32'(log_addr[3]), 32'h001);
    check("wrap:data3", log_data[3], 32'hA3);

    // Random 0-3 cycle stalls
    begin_op("stall", 'h0C0, 24, 1'b1, 32'h12345678, 3);
    finish_op("stall", 'h0C0, 24, 1'b1, 32'h12345678, 0, 0);

    // Zero-length command: no traffic, done one cycle later
    clear_track();
    stall_max = 0;
    start_op('h123, 0, 1'b0, 32'h0);
    check("zero:done", 32'(done), 32'd1);
    check("zero:busy", 32'(busy), 32'd0);
    @(negedge clk_clk);
    check("zero:done_cleared", 32'(done), 32'd0);
    check("zero:no_writes", 32'(wr_accepts), 32'd0);
    check("zero:no_reads", 32'(rd_accepts), 32'd0);

    // Start while busy is ignored
    begin_op("busy_start", 'h300, 8, 1'b1, 32'h55, 3);
    @(negedge clk_clk);
    base_addr = 10'h000;
    word_cnt  = 11'd3;
    start     = 1'b1;
    @(negedge clk_clk);
    start = 1'b0;
    finish_op("busy_start", 'h300, 8, 1'b1, 32'h55, 0, 0);

    // Full range with stalls; data sum wraps modulo 2^32
    begin_op("full", 'h155, 1024, 1'b1, 32'hFFFFFF00, 3);
    finish_op("full", 'h155, 1024, 1'b1, 32'hFFFFFF00, 0, 0);

    // Oversized count clamps to 1024
    begin_op("clamp", 'h000, 1500, 1'b0, 32'h5A5A5A5A, 0);
    finish_op("clamp", 'h000, 1500, 1'b0, 32'h5A5A5A5A, 0, 0);

`ifdef HDMI_MM_READBACK_EN
    // Pipelined reads against a latency-5 slave fill the outstanding window
    begin_op("pipe", 'h080, 16, 1'b1, 32'h40, 0);
    finish_op("pipe", 'h080, 16, 1'b1, 32'h40, 0, 0);
    check("pipe:max_pend", 32'(max_out), 32'd4);

    // Single corrupted word reported by count and address
    corrupt_addr = 'h012;
    begin_op("mismatch", 'h010, 4, 1'b1, 32'h100, 0);
    finish_op("mismatch", 'h010, 4, 1'b1, 32'h100, 1, 'h012);
    corrupt_addr = -1;
`endif

    // Reset mid-WRITE drops outputs at once and never completes
    clear_track();
    stall_max = 0;
    start_op('h100, 16, 1'b1, 32'h5);
    repeat (2) @(negedge clk_clk);
    check("midreset:writing", 32'(master_write), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);
    check("midreset:no_done", 32'(done_pulses), 32'd0);
    check("midreset:idle_busy", 32'(busy), 32'd0);

    // Normal operation after reset
    begin_op("post_reset", 'h3F0, 2, 1'b1, 32'h77, 0);
    finish_op("post_reset", 'h3F0, 2, 1'b1, 32'h77, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hdmi_mm_fill_master.md
Name: hdmi_mm_fill_master

Overview:
- Avalon-MM master that drives the HDMI subsystem's 32-bit Avalon-MM slave (10-bit word address, single-beat).
- On a start command it writes a generated pattern over a word range of the frame/register memory.
- Optionally reads the range back with pipelined reads and counts mismatches.
- Sits beside the HDMI Qsys system as the initiator for board test and frame initialisation.

Parameters:
- ADDR_W, 10, word address width of the slave port.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_PEND, 4, maximum outstanding reads (1..8).

Ports:
- clk_clk  in  1  system clock, shared with the slave.
- reset_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- base_addr  in  ADDR_W  first word address; sampled on accepted start.
- word_cnt  in  ADDR_W+1  number of words, 0..1024; values >1024 clamp to 1024; sampled on start.
- pattern_mode  in  1  0 = constant seed, 1 = seed+index; sampled on start.
- pattern_seed  in  DATA_W  pattern seed; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at operation end.
- err_cnt  out  ADDR_W+1  readback mismatches of the last operation; saturates at 1024.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- master_write  out  1  Avalon write request.
- master_read  out  1  Avalon read request.
- master_address  out  ADDR_W  word address.
- master_writedata  out  DATA_W  write data.
- master_burstcount  out  1  constant 1.
- master_byteenable  out  DATA_W/8  constant all-ones.
- master_waitrequest  in  1  slave stall.
- master_readdatavalid  in  1  read data valid.
- master_readdata  in  DATA_W  read data.

Behaviour:
- Reset values: all outputs 0 except master_burstcount=1 and master_byteenable=all-ones. FSM goes to IDLE; counters clear. Reset mid-operation abandons the transaction with no completion.
- FSM states: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE: start with word_cnt=0 goes to FINISH; done pulses the next cycle; no bus traffic. Any other start latches inputs, clears err_cnt/first_err_addr, and goes to WRITE.
- WRITE: master_write=1 with address=(base_addr+i) mod 2^ADDR_W and data=pattern(i).
  - pattern(i) = seed (mode 0) or seed+i mod 2^DATA_W (mode 1).
  - Request, address and data hold stable while master_waitrequest=1.
  - i increments only on write && !waitrequest.
  - After the last accepted write, go to READ, or to FINISH without readback.
  - Back-to-back writes, one per cycle, when waitrequest=0.
- READ: issue index j; master_read=1 while j<cnt and pend<MAX_PEND. Held under waitrequest; j advances on acceptance.
  - pend +1 on accepted read, −1 on readdatavalid; both in one cycle leave it unchanged.
  - After the last accepted read, go to DRAIN.
- DRAIN: wait for pend=0, then go to FINISH.
- Compare: independent index k advances on each readdatavalid (in-order responses).
  - A mismatch against pattern(k) increments err_cnt (saturating).
  - The first mismatch captures (base_addr+k) mod 2^ADDR_W.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. err_cnt and first_err_addr hold until the next start.
- Wrap-around: range crossing the top address wraps to 0. word_cnt=1024 touches every word exactly once.
- master_read and master_write are never both asserted.

Optional Feature:
- HDMI_MM_READBACK_EN defined: READ/DRAIN phases and compare logic present, as above.
- Undefined: WRITE goes directly to FINISH. master_read, err_cnt and first_err_addr are tied 0. readdatavalid is ignored.

Decomposition:
- Package hdmi_mm_pkg: FSM state enum, ADDR_W/DATA_W defaults, MAX_WORDS=1024 constant, pattern_mode encoding.
- Sub-module hdmi_mm_pattern_gen: combinational pattern(index, seed, mode). Instantiated once for write data and once for the compare expectation.

Test Plan:
- Basic fill: base=0x010, cnt=4, mode 1, seed 0x100, no waitrequest → writes 0x100..0x103 at 0x010..0x013 on 4 consecutive cycles; readback matches; err_cnt=0; done pulses once.
- Waitrequest stall: random 0–3 cycle stalls → address/data stable while stalled; each word written exactly once; accepted count equals cnt.
- Wrap and full range: base=0x3FE, cnt=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001. cnt=1024 → 1024 unique writes.
- Pipelined read: readdatavalid latency 5 → pend never exceeds 4; DRAIN waits for the final response.
- Mismatch: slave model corrupts word at 0x012 → err_cnt=1, first_err_addr=0x012.
- Edge cases: cnt=0 → no traffic, done 1 cycle later. Start while busy → ignored. Reset mid-WRITE → outputs return to reset values immediately.
